pc_regfile_exec: RTL
====================

Name: pc_regfile_exec

Overview:
- Execute-side counterpart of the fetch/decode block.
- Consumes `instr`, `immop` and the control signals (`regwrite`, `aluctrl`, `alusrc`, `pcsrc`).
- Produces `pc` and `eq` back to fetch/decode.
- Contains the program counter register, a 32-entry register file with x0 hardwired to zero, and the ALU. Also exposes register a0 (x10) for observation.

Parameters:
- ADDRESS_WIDTH, 32, width of `pc`, `instr`, `immop` and all data paths.
- REG_ADDR_WIDTH, 5, register index width (32 registers).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- en  input  1  execute enable; 0 freezes PC and blocks register writes.
- instr  input  ADDRESS_WIDTH  current instruction; rs1=[19:15], rs2=[24:20], rd=[11:7].
- immop  input  ADDRESS_WIDTH  sign-extended immediate.
- regwrite  input  1  write ALU result to rd.
- aluctrl  input  3  ALU operation select.
- alusrc  input  1  0: ALU operand B = rs2 value; 1: ALU operand B = immop.
- pcsrc  input  1  1: branch taken.
- pc  output  ADDRESS_WIDTH  current program counter (registered).
- eq  output  1  ALU operand A == operand B (combinational).
- a0  output  ADDRESS_WIDTH  current contents of x10 (combinational from storage).

Behaviour:
- Reset: when rst_n=0 at a rising edge:
  - pc <= RESET_PC.
  - All 32 registers <= 0, so a0 = 0.
  - Register writes that cycle are suppressed, regardless of en/regwrite.
  - eq follows the reset register values; with x0 sources it is 1.
- Reset mid-operation overrides everything; there is no partial state.
- PC update on each rising edge with rst_n=1 and en=1:
  - pcsrc=1: pc <= pc + immop (modulo 2^ADDRESS_WIDTH; negative immop wraps).
  - pcsrc=0: pc <= pc + 4 (wraps from 32'hFFFF_FFFC to 0).
- en=0: pc holds and no register write occurs.
- Register read: rs1/rs2 values are combinational from storage; x0 always reads 0.
- Register write on rising edge when rst_n=1, en=1, regwrite=1 and rd != 0: reg[rd] <= alu_result.
  - Writes to rd=0 are discarded.
- Read-during-write: a same-cycle read of rd returns the old value; the new value is visible after the edge (no bypass).
- ALU: operand A = reg[rs1]; operand B = alusrc ? immop : reg[rs2].
  - 000 add A+B (wrap, no overflow flag).
  - 001 sub A-B.
  - 010 and.
  - 011 or.
  - 101 slt (signed A<B ? 1 : 0).
  - 111 operand B pass-through (load-immediate style).
  - 100 and 110 are reserved and yield 0.
- eq = (A == B) as full-width compare, independent of aluctrl.
  - Feeds fetch/decode within the same cycle, so branch resolution is single-cycle.
- Latency: fully single-cycle; instruction effects (pc, register) are visible one edge after presentation.
- Simultaneous regwrite=1 and pcsrc=1 are both honoured on the same edge.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with en=1, regwrite=1, rd=10, immop=5, alusrc=1 -> pc=0, a0=0 throughout. Then release with pcsrc=0 -> pc sequence 4, 8, 12.
2. Addi: instr rs1=0, rd=10, immop=32'h0000_00FF, alusrc=1, aluctrl=000, regwrite=1 -> a0=0 before the edge, 32'hFF after. Repeat with rs1=10 -> a0=32'h1FE.
3. Branch: x10=5, immop=5, alusrc=1, aluctrl=001 -> eq=1. With pcsrc=1 and pc=8, immop=-8 (32'hFFFF_FFF8) -> pc=0 next edge. Change immop to 4 -> eq=0.
4. x0 protection: regwrite=1, rd=0, immop=32'hDEAD_BEEF, alusrc=1 -> reading rs1=0 with aluctrl=000, B=0 still gives eq=1. a0 is unchanged.
5. Enable hold: en=0 for 3 cycles with regwrite=1, rd=10, pcsrc=1 -> pc and a0 constant. en=1 resumes from the held pc.
6. Wrap and slt: pc preset via branch to 32'hFFFF_FFFC, pcsrc=0 -> pc=0. x10=-1, immop=1, aluctrl=101, rd=11, then read x11 via rs1 -> result 1.

Source files
------------

// File: rtl/pc_regfile_exec.sv
// Execute-side datapath: program counter, 32-entry register file (x0 reads zero) and ALU.
// Single-cycle: branch compare and ALU are combinational, pc/register updates on clk rise.
module pc_regfile_exec #(
  parameter int unsigned               ADDRESS_WIDTH  = 32,
  parameter int unsigned               REG_ADDR_WIDTH = 5,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [ADDRESS_WIDTH-1:0]  instr,
  input  logic [ADDRESS_WIDTH-1:0]  immop,
  input  logic                      regwrite,
  input  logic [2:0]                aluctrl,
  input  logic                      alusrc,
  input  logic                      pcsrc,
  output logic [ADDRESS_WIDTH-1:0]  pc,
  output logic                      eq,
  output logic [ADDRESS_WIDTH-1:0]  a0
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_WIDTH;
  localparam int unsigned A0Idx   = 10;

  typedef enum logic [2:0] {
    AluAdd  = 3'b000,
    AluSub  = 3'b001,
    AluAnd  = 3'b010,
    AluOr   = 3'b011,
    AluRsv4 = 3'b100,
    AluSlt  = 3'b101,
    AluRsv6 = 3'b110,
    AluPass = 3'b111
  } alu_op_e;

  // Instruction field extraction
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd;

  assign rs1 = instr[15 +: REG_ADDR_WIDTH];
  assign rs2 = instr[20 +: REG_ADDR_WIDTH];
  assign rd  = instr[7 +: REG_ADDR_WIDTH];

  // Opcode/funct bits are decoded upstream; gathered here so they are visibly consumed.
  logic unused_instr;
  assign unused_instr = ^{instr[ADDRESS_WIDTH-1:20+REG_ADDR_WIDTH], instr[14:12], instr[6:0]};

  // State
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] regs_q [NumRegs];

  // Datapath signals
  logic [ADDRESS_WIDTH-1:0] rs1_val;
  logic [ADDRESS_WIDTH-1:0] rs2_val;
  logic [ADDRESS_WIDTH-1:0] op_a;
  logic [ADDRESS_WIDTH-1:0] op_b;
  logic [ADDRESS_WIDTH-1:0] alu_result;
  logic                     reg_we;
  alu_op_e                  alu_op;

  assign alu_op = alu_op_e'(aluctrl);

  // Register reads straight from storage; x0 forced to zero, no write bypass.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = regs_q[rs1];
    if (rs2 != '0) rs2_val = regs_q[rs2];
  end

  // Operand selection
  always_comb begin
    op_a = rs1_val;
    op_b = alusrc ? immop : rs2_val;
  end

  // ALU; reserved encodings yield zero
  always_comb begin
    alu_result = '0;
    unique case (alu_op)
      AluAdd:  alu_result = op_a + op_b;
      AluSub:  alu_result = op_a - op_b;
      AluAnd:  alu_result = op_a & op_b;
      AluOr:   alu_result = op_a | op_b;
      AluSlt:  alu_result = ($signed(op_a) < $signed(op_b)) ?
                            ADDRESS_WIDTH'(1) : '0;
      AluPass: alu_result = op_b;
      AluRsv4,
      AluRsv6: alu_result = '0;
      default: alu_result = '0;
    endcase
  end

  // Branch compare is independent of the ALU operation
  always_comb begin
    eq = (op_a == op_b);
  end

  // Next pc: branch target or sequential; both wrap modulo 2^ADDRESS_WIDTH
  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = pcsrc ? (pc_q + immop) : (pc_q + ADDRESS_WIDTH'(4));
    end
  end

  // Write strobe; rd=0 writes are dropped so x0 storage never changes
  always_comb begin
    reg_we = en & regwrite & (rd != '0);
  end

  // Program counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Register file storage; reset clears every entry and suppresses the write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[rd] <= alu_result;
    end
  end

  // Outputs
  always_comb begin
    pc = pc_q;
    a0 = regs_q[A0Idx];
  end

endmodule
